// File: rtl/bitonic_result_serializer_pkg.sv
// Shared sorter parameters: default element width and vector size used by the
// bitonic sorter result path.
package bitonic_result_serializer_pkg;

    // log2 of the number of elements in one sorted vector
    localparam int SORTER_LOG_INPUT_NUM = 4;
    // width of one sorted element
    localparam int SORTER_DATA_WIDTH    = 8;

endpackage

// File: rtl/bitonic_result_serializer_vector_fifo2.sv
// Two-entry FIFO holding whole sorted vectors. A push is accepted when a slot
// is free, or when the FIFO is full and the head is popped in the same cycle.
module vector_fifo2
    import bitonic_result_serializer_pkg::*;
#(
    parameter int WIDTH = SORTER_DATA_WIDTH * (2 ** SORTER_LOG_INPUT_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t             state_q, state_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr;
    logic             push_ok, pop_ok;
    logic [WIDTH-1:0] mem_q [2];

    // Accept/pop qualification, write slot selection and next occupancy.
    always_comb begin
        pop_ok   = pop && (state_q != EMPTY);
        push_ok  = push && ((state_q != TWO) || pop_ok);
        // With one entry the free slot is the other one; when empty, or full
        // with a simultaneous pop, the slot under the read pointer is free.
        wr_ptr   = (state_q == ONE) ? ~rd_ptr_q : rd_ptr_q;
        rd_ptr_d = pop_ok ? ~rd_ptr_q : rd_ptr_q;
        state_d  = state_q;
        unique case (state_q)
            EMPTY: if (push_ok)             state_d = ONE;
            ONE: begin
                if (push_ok && !pop_ok)     state_d = TWO;
                else if (pop_ok && !push_ok) state_d = EMPTY;
            end
            TWO:   if (pop_ok && !push_ok)  state_d = ONE;
            default:                        state_d = EMPTY;
        endcase
    end

    // Occupancy state and read pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Vector storage; contents are meaningless while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr] <= din;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (state_q == TWO);
    assign empty = (state_q == EMPTY);
    assign count = state_q;

endmodule

// File: rtl/bitonic_result_serializer.sv
// Serializes sorted vectors from the bitonic sorter into a valid/ready element
// stream, element 0 first, with a two-vector buffer and a sticky drop flag.
module bitonic_result_serializer
    import bitonic_result_serializer_pkg::*;
#(
    parameter int LOG_INPUT_NUM = SORTER_LOG_INPUT_NUM,
    parameter int DATA_WIDTH    = SORTER_DATA_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    x_valid,
    input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0] x,
    output logic [DATA_WIDTH-1:0]                   m_data,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic                                    m_last,
    output logic [LOG_INPUT_NUM-1:0]                m_index,
    output logic                                    overflow,
    output logic                                    busy
);

    localparam int N  = 2 ** LOG_INPUT_NUM;
    localparam int VW = DATA_WIDTH * N;
    localparam logic [LOG_INPUT_NUM-1:0] LAST_IDX = LOG_INPUT_NUM'(N - 1);

    logic [VW-1:0]            head;
    logic                     fifo_full, fifo_empty;
    logic [1:0]               fifo_count;
    logic                     push, pop, xfer, drop;
    logic [LOG_INPUT_NUM-1:0] index_q, index_d;
    logic                     overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]    elem [N];

    vector_fifo2 #(
        .WIDTH (VW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (x),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Handshake decode; the index wraps to 0 on its own after the last element.
    always_comb begin
        xfer       = !fifo_empty && m_ready;
        pop        = xfer && (index_q == LAST_IDX);
        push       = x_valid && !rst;
        drop       = x_valid && fifo_full && !pop;
        index_d    = xfer ? index_q + LOG_INPUT_NUM'(1) : index_q;
        overflow_d = overflow_q | drop;
    end

    // Element index within the head vector and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            index_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            index_q    <= index_d;
            overflow_q <= overflow_d;
        end
    end

    // Split the head vector into its elements for the output mux.
    for (genvar gi = 0; gi < N; gi++) begin : g_elem
        assign elem[gi] = head[DATA_WIDTH*gi +: DATA_WIDTH];
    end

    assign m_data   = elem[index_q];
    assign m_valid  = !fifo_empty;
    assign m_index  = index_q;
    assign m_last   = !fifo_empty && (index_q == LAST_IDX);
    assign busy     = (fifo_count != 2'd0);
    assign overflow = overflow_q;

endmodule
